// File: rtl/conv_pkg.sv
// Shared state encoding and window indexing helper for the KxK window generator.
package conv_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_FILL = 2'd1;
   localparam logic [1:0] ST_RUN  = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE = ST_IDLE,
      S_FILL = ST_FILL,
      S_RUN  = ST_RUN,
      S_DONE = ST_DONE
   } state_t;

   // Flattened window slot of row r (0 = top), column c (0 = leftmost).
   function automatic int win_idx(input int r, input int c, input int ksize);
      return r * ksize + c;
   endfunction

endpackage

// File: rtl/win_shift_row.sv
// One window row: KSIZE words shifted towards column 0, new word entering at column KSIZE-1.
module win_shift_row #(
   parameter int WORDWIDTH = 32,
   parameter int KSIZE     = 3
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       i_en,
   input  logic [WORDWIDTH-1:0]       i_din,
   output logic [KSIZE*WORDWIDTH-1:0] o_row
);

   logic [KSIZE*WORDWIDTH-1:0] r_row;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_row <= '0;
      end else if (i_en) begin
         r_row <= {i_din, r_row[KSIZE*WORDWIDTH-1:WORDWIDTH]};
      end
   end

   assign o_row = r_row;

endmodule

// File: rtl/conv_window_gen.sv
// KxK sliding-window generator fed by the live pixel stream and the line-buffer taps.
// Optional macro WIN_TAP_CHECK_EN adds a sticky tap_err output checking tap_valid alignment.
module conv_window_gen
   import conv_pkg::*;
#(
   parameter int WORDWIDTH  = 32,
   parameter int FIG_WIDTH  = 28,
   parameter int FIG_HEIGHT = 28,
   parameter int KSIZE      = 3,
   parameter int CNT_W      = 5
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             sof,
   input  logic [WORDWIDTH-1:0]             pix_in,
   input  logic                             pix_valid,
   input  logic [(KSIZE-1)*WORDWIDTH-1:0]   tap_in,
   input  logic [KSIZE-2:0]                 tap_valid,
   output logic [KSIZE*KSIZE*WORDWIDTH-1:0] win_out,
   output logic                             win_valid,
   output logic [CNT_W-1:0]                 win_row,
   output logic [CNT_W-1:0]                 win_col,
   output logic                             frame_done,
   output logic                             busy
`ifdef WIN_TAP_CHECK_EN
   ,
   output logic                             tap_err
`endif
);

   localparam logic [CNT_W-1:0] LP_COL_MAX = CNT_W'(FIG_WIDTH - 1);
   localparam logic [CNT_W-1:0] LP_ROW_MAX = CNT_W'(FIG_HEIGHT - 1);
   localparam logic [CNT_W-1:0] LP_K1      = CNT_W'(KSIZE - 1);

   logic [WORDWIDTH-1:0] r_pix_p1;
   logic                 r_pv_p1;
   logic                 r_sof_p1;
   logic [CNT_W-1:0]     r_row;
   logic [CNT_W-1:0]     r_col;
   logic [CNT_W-1:0]     w_row;
   logic [CNT_W-1:0]     w_col;
   logic [CNT_W-1:0]     w_row_nxt;
   logic [CNT_W-1:0]     w_col_nxt;
   logic                 w_last;
   logic                 w_corner;
   logic                 r_win_valid;
   logic [CNT_W-1:0]     r_win_row;
   logic [CNT_W-1:0]     r_win_col;
   logic                 r_frame_done;
   state_t               r_state;
   state_t               w_state_nxt;

   // Stage p1: align the live pixel with the one-cycle line-buffer read lag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pix_p1 <= '0;
         r_pv_p1  <= 1'b0;
         r_sof_p1 <= 1'b0;
      end else begin
         r_pix_p1 <= pix_in;
         r_pv_p1  <= pix_valid;
         r_sof_p1 <= sof & pix_valid;
      end
   end

   // A qualified sof makes the aligned pixel (0,0) regardless of where the counters were.
   assign w_row    = r_sof_p1 ? '0 : r_row;
   assign w_col    = r_sof_p1 ? '0 : r_col;
   assign w_last   = (w_row == LP_ROW_MAX) && (w_col == LP_COL_MAX);
   assign w_corner = (w_row == LP_K1) && (w_col == LP_K1);

   always_comb begin
      w_col_nxt = w_col + 1'b1;
      w_row_nxt = w_row;
      if (w_col == LP_COL_MAX) begin
         w_col_nxt = '0;
         w_row_nxt = (w_row == LP_ROW_MAX) ? '0 : w_row + 1'b1;
      end
   end

   // Stage p2: shift window, advance counters, register window qualifiers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_row       <= '0;
         r_col       <= '0;
         r_win_valid <= 1'b0;
         r_win_row   <= '0;
         r_win_col   <= '0;
      end else begin
         r_win_valid <= r_pv_p1 && (w_row >= LP_K1) && (w_col >= LP_K1);
         if (r_pv_p1) begin
            r_row     <= w_row_nxt;
            r_col     <= w_col_nxt;
            r_win_row <= w_row;
            r_win_col <= w_col;
         end
      end
   end

   for (genvar r = 0; r < KSIZE; r++) begin : g_row
      logic [WORDWIDTH-1:0]       w_din;
      logic [KSIZE*WORDWIDTH-1:0] w_row_data;

      if (r == KSIZE - 1) begin : g_bottom
         assign w_din = r_pix_p1;
      end else begin : g_tap
         assign w_din = tap_in[(KSIZE-2-r)*WORDWIDTH +: WORDWIDTH];
      end

      win_shift_row #(
         .WORDWIDTH (WORDWIDTH),
         .KSIZE     (KSIZE)
      ) u_row (
         .clk   (clk),
         .rst   (rst),
         .i_en  (r_pv_p1),
         .i_din (w_din),
         .o_row (w_row_data)
      );

      assign win_out[win_idx(r, 0, KSIZE)*WORDWIDTH +: KSIZE*WORDWIDTH] = w_row_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_frame_done <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_frame_done <= (r_state == S_DONE) && !(r_pv_p1 && r_sof_p1);
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      if (r_pv_p1) begin
         if (r_sof_p1) begin
            w_state_nxt = S_FILL;
         end else begin
            case (r_state)
               S_IDLE:  w_state_nxt = S_FILL;
               S_FILL:  begin
                  if (w_last)        w_state_nxt = S_DONE;
                  else if (w_corner) w_state_nxt = S_RUN;
               end
               S_RUN:   if (w_last) w_state_nxt = S_DONE;
               S_DONE:  w_state_nxt = S_FILL;
               default: w_state_nxt = S_IDLE;
            endcase
         end
      end else if (r_state == S_DONE) begin
         w_state_nxt = S_IDLE;
      end
   end

   assign win_valid  = r_win_valid;
   assign win_row    = r_win_row;
   assign win_col    = r_win_col;
   assign frame_done = r_frame_done;
   assign busy       = (r_state == S_FILL) || (r_state == S_RUN);

`ifdef WIN_TAP_CHECK_EN
   logic r_tap_err;
   logic w_tap_bad;

   // A tap is required once the pixel has i+1 rows above it, and must never be valid on its own.
   always_comb begin
      w_tap_bad = 1'b0;
      for (int i = 0; i < KSIZE - 1; i++) begin
         if (r_pv_p1 && (w_row >= CNT_W'(i + 1)) && !tap_valid[i]) w_tap_bad = 1'b1;
         if (tap_valid[i] && !r_pv_p1)                             w_tap_bad = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_tap_err <= 1'b0;
      end else if (w_tap_bad) begin
         r_tap_err <= 1'b1;
      end
   end

   assign tap_err = r_tap_err;
`else
   logic w_unused_tap_valid;
   assign w_unused_tap_valid = |tap_valid;
`endif

endmodule

// File: tb/tb_conv_window_gen.sv
// Directed bench for conv_window_gen with a line-buffer tap model and a window scoreboard.
module tb_conv_window_gen;

   localparam int WW = 8;
   localparam int FW = 5;
   localparam int FH = 5;
   localparam int K  = 3;
   localparam int CW = 3;

   logic                    clk = 1'b0;
   logic                    rst;
   logic                    sof;
   logic [WW-1:0]           pix_in;
   logic                    pix_valid;
   logic [(K-1)*WW-1:0]     tap_in;
   logic [K-2:0]            tap_valid;
   logic [K*K*WW-1:0]       win_out;
   logic                    win_valid;
   logic [CW-1:0]           win_row;
   logic [CW-1:0]           win_col;
   logic                    frame_done;
   logic                    busy;
`ifdef WIN_TAP_CHECK_EN
   logic                    tap_err;
`endif

   conv_window_gen #(
      .WORDWIDTH  (WW),
      .FIG_WIDTH  (FW),
      .FIG_HEIGHT (FH),
      .KSIZE      (K),
      .CNT_W      (CW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .sof        (sof),
      .pix_in     (pix_in),
      .pix_valid  (pix_valid),
      .tap_in     (tap_in),
      .tap_valid  (tap_valid),
      .win_out    (win_out),
      .win_valid  (win_valid),
      .win_row    (win_row),
      .win_col    (win_col),
      .frame_done (frame_done),
      .busy       (busy)
`ifdef WIN_TAP_CHECK_EN
      ,
      .tap_err    (tap_err)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      int                cyc;
      int                r;
      int                c;
      logic [K*K*WW-1:0] win;
   } exp_t;

   exp_t sb[$];
   int   n_assert = 0;
   int   n_fail   = 0;
   int   cyc      = 0;
   int   fd_cycle = -1;
   int   n_win    = 0;
   bit   prev_v   = 1'b0;
   int   prev_r   = 0;
   int   prev_c   = 0;
   bit   drop_arm = 1'b0;
   bit   drop_tv1 = 1'b0;

   function automatic logic [WW-1:0] pval(input int r, input int c);
      return WW'(16 * r + c);
   endfunction

   function automatic logic [K*K*WW-1:0] ewin(input int r, input int c);
      logic [K*K*WW-1:0] w;
      w = '0;
      for (int rr = 0; rr < K; rr++)
         for (int cc = 0; cc < K; cc++)
            w[(rr*K+cc)*WW +: WW] = pval(r - K + 1 + rr, c - K + 1 + cc);
      return w;
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic sample();
      exp_t e;
      chk("frame_done", frame_done, (cyc == fd_cycle));
      if (win_valid) begin
         if (sb.size() == 0) begin
            chk("win_valid_unexpected", win_valid, 1'b0);
         end else begin
            e = sb.pop_front();
            n_win++;
            chk("win_latency", cyc, e.cyc + 2);
            chk("win_row", win_row, e.r);
            chk("win_col", win_col, e.c);
            chk("win_out", win_out, e.win);
         end
      end
   endtask

   // One clock: drive pixel, line-buffer taps of the previous pixel, then sample.
   task automatic step(input bit v, input bit s, input int r, input int c);
      exp_t e;
      pix_valid = v;
      sof       = s;
      pix_in    = v ? pval(r, c) : '0;
      tap_in    = '0;
      tap_valid = '0;
      if (prev_v) begin
         for (int i = 0; i < K - 1; i++) begin
            if (prev_r >= i + 1) begin
               tap_in[i*WW +: WW] = pval(prev_r - i - 1, prev_c);
               tap_valid[i]       = 1'b1;
            end
         end
      end
      if (drop_tv1) tap_valid[1] = 1'b0;
      drop_tv1 = drop_arm && v && (r == 3) && (c == 0);
      if (v && r >= K - 1 && c >= K - 1) begin
         e.cyc = cyc;
         e.r   = r;
         e.c   = c;
         e.win = ewin(r, c);
         sb.push_back(e);
      end
      if (v && r == FH - 1 && c == FW - 1) fd_cycle = cyc + 3;
      prev_v = v;
      prev_r = r;
      prev_c = c;
      @(posedge clk);
      #1;
      cyc++;
      sample();
   endtask

   task automatic run_frame(input bit gaps);
      for (int r = 0; r < FH; r++) begin
         for (int c = 0; c < FW; c++) begin
            if (gaps) begin
               for (int g = 0; g < 4 && $urandom_range(1) == 1; g++) step(1'b0, 1'b0, 0, 0);
            end
            step(1'b1, (r == 0 && c == 0), r, c);
         end
      end
   endtask

   task automatic drain(input string tag);
      repeat (6) step(1'b0, 1'b0, 0, 0);
      chk({tag, "_sb_empty"}, sb.size(), 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; sof = 1'b0; pix_in = '0; pix_valid = 1'b0; tap_in = '0; tap_valid = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_win_valid", win_valid, 1'b0);
      chk("rst_win_out", win_out, '0);
      chk("rst_win_row", win_row, '0);
      chk("rst_win_col", win_col, '0);
      chk("rst_frame_done", frame_done, 1'b0);
      chk("rst_busy", busy, 1'b0);
`ifdef WIN_TAP_CHECK_EN
      chk("rst_tap_err", tap_err, 1'b0);
`endif
      rst = 1'b0;
      step(1'b0, 1'b0, 0, 0);

      // Full frame, continuous valid; includes the row-wrap windows.
      n_win = 0;
      for (int i = 0; i < FW * FH; i++) begin
         step(1'b1, i == 0, i / FW, i % FW);
         if (i == 7) chk("t1_busy_mid", busy, 1'b1);
      end
      drain("t1");
      chk("t1_nwin", n_win, 9);
      chk("t1_busy_after", busy, 1'b0);

      // Same frame with random valid gaps.
      n_win = 0;
      run_frame(1'b1);
      drain("t2");
      chk("t2_nwin", n_win, 9);

      // sof at what would be pixel (3,1): restart, no frame_done for the aborted frame.
      n_win = 0;
      for (int i = 0; i < 3 * FW + 1; i++) step(1'b1, i == 0, i / FW, i % FW);
      run_frame(1'b0);
      drain("t4");
      chk("t4_nwin", n_win, 3 + 9);

      // Asynchronous reset mid-frame after pixel (2,3).
      for (int i = 0; i <= 2 * FW + 3; i++) step(1'b1, i == 0, i / FW, i % FW);
      pix_valid = 1'b0; tap_valid = '0; tap_in = '0; sof = 1'b0;
      rst = 1'b1;
      #2;
      chk("t5_win_valid", win_valid, 1'b0);
      chk("t5_win_out", win_out, '0);
      chk("t5_win_row", win_row, '0);
      chk("t5_frame_done", frame_done, 1'b0);
      chk("t5_busy", busy, 1'b0);
      sb.delete();
      fd_cycle = -1;
      prev_v   = 1'b0;
      @(posedge clk);
      #1;
      cyc++;
      rst = 1'b0;
      step(1'b0, 1'b0, 0, 0);
      chk("t5_busy_idle", busy, 1'b0);
      n_win = 0;
      run_frame(1'b0);
      drain("t5");
      chk("t5_nwin", n_win, 9);

`ifdef WIN_TAP_CHECK_EN
      chk("t6_tap_err_clean", tap_err, 1'b0);
      drop_arm = 1'b1;
      n_win = 0;
      run_frame(1'b0);
      drop_arm = 1'b0;
      drain("t6");
      chk("t6_tap_err_set", tap_err, 1'b1);
      run_frame(1'b0);
      drain("t6b");
      chk("t6_tap_err_sticky", tap_err, 1'b1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
